// File: rtl/sram_sp_bwe_init.sv
// Behavioural single-port synchronous SRAM with per-bit active-low write mask and a post-reset clear sequencer.
// Define SRAM_RAND_OUT_EN to drive Q with pseudo-random data on every cycle that is not a read.
module sram_sp_bwe_init #(
    parameter int Bits       = 261,
    parameter int Word_Depth = 4,
    parameter int Add_Width  = 2
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 CEB,
    input  logic                 WEB,
    input  logic [Bits-1:0]      BWEB,
    input  logic [Add_Width-1:0] A,
    input  logic [Bits-1:0]      D,
    output logic [Bits-1:0]      Q,
    output logic                 INIT_DONE
);

    // state | meaning
    // CLEAR | zeroing the array one word per edge; accesses ignored
    // DONE  | clear finished, array accepts reads and writes
    typedef enum logic {
        CLEAR = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [Add_Width-1:0] LAST_WORD = Add_Width'(Word_Depth - 1);

    state_t                 state;
    logic [Add_Width-1:0]   cnt;
    logic [Bits-1:0]        ram [Word_Depth];

    logic addr_ok;
    logic acc_wr;
    logic acc_rd;

    assign addr_ok = (32'(A) < 32'(Word_Depth));
    assign acc_wr  = (state == DONE) && !CEB && !WEB && addr_ok;
    assign acc_rd  = (state == DONE) && !CEB && WEB;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state     <= CLEAR;
            cnt       <= '0;
            INIT_DONE <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    // Counter parks on the last word instead of wrapping.
                    if (cnt == LAST_WORD) begin
                        state     <= DONE;
                        INIT_DONE <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= DONE;
                    INIT_DONE <= 1'b1;
                end
                default: begin
                    state     <= CLEAR;
                    cnt       <= '0;
                    INIT_DONE <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; contents are rebuilt by the clear sequence.
    always_ff @(posedge CLK) begin
        if (state == CLEAR) begin
            ram[cnt] <= '0;
        end else if (acc_wr) begin
            ram[A] <= (ram[A] & BWEB) | (D & ~BWEB);
        end
    end

`ifdef SRAM_RAND_OUT_EN
    localparam int RAND_WORDS = (Bits + 31) / 32;

    function automatic logic [Bits-1:0] rand_word();
        logic [RAND_WORDS*32-1:0] r;
        r = '0;
        for (int i = 0; i < RAND_WORDS; i++) begin
            r[i*32 +: 32] = $random;
        end
        return r[Bits-1:0];
    endfunction

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            Q <= '0;
        end else if (acc_rd) begin
            Q <= addr_ok ? ram[A] : 'x;
        end else begin
            Q <= rand_word();
        end
    end
`else
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            Q <= '0;
        end else if (acc_rd) begin
            Q <= addr_ok ? ram[A] : 'x;
        end
    end
`endif

endmodule

// File: tb/tb_sram_sp_bwe_init.sv
// Directed bench for sram_sp_bwe_init: a Word_Depth=4 instance and a Word_Depth=5/Add_Width=3 instance.
module tb_sram_sp_bwe_init;

    localparam int BITS = 261;
    localparam logic [BITS-1:0] ONES  = {BITS{1'b1}};
    localparam logic [BITS-1:0] ZERO  = '0;
    localparam logic [BITS-1:0] LOWER = {130'b0, {131{1'b1}}};
    localparam logic [BITS-1:0] PAT   = {5'h15, {8{32'hA5C3_1E77}}};
    localparam logic [BITS-1:0] M8    = {253'b0, 8'hFF};

    logic            clk;
    logic            rstb, ceb, web;
    logic [BITS-1:0] bweb, d, q;
    logic [1:0]      a;
    logic            init_done;

    logic            rstb5, ceb5, web5;
    logic [BITS-1:0] bweb5, d5, q5;
    logic [2:0]      a5;
    logic            init_done5;

    int checks   = 0;
    int failures = 0;

    sram_sp_bwe_init #(.Bits(BITS), .Word_Depth(4), .Add_Width(2)) dut (
        .CLK(clk), .RSTB(rstb), .CEB(ceb), .WEB(web), .BWEB(bweb),
        .A(a), .D(d), .Q(q), .INIT_DONE(init_done)
    );

    sram_sp_bwe_init #(.Bits(BITS), .Word_Depth(5), .Add_Width(3)) dut5 (
        .CLK(clk), .RSTB(rstb5), .CEB(ceb5), .WEB(web5), .BWEB(bweb5),
        .A(a5), .D(d5), .Q(q5), .INIT_DONE(init_done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic c, input logic w, input logic [1:0] ad,
                       input logic [BITS-1:0] dd, input logic [BITS-1:0] bw);
        ceb = c; web = w; a = ad; d = dd; bweb = bw;
    endtask

    task automatic acc5(input logic c, input logic w, input logic [2:0] ad,
                        input logic [BITS-1:0] dd, input logic [BITS-1:0] bw);
        ceb5 = c; web5 = w; a5 = ad; d5 = dd; bweb5 = bw;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b1;
        rstb5 = 1'b1;
        acc(1'b1, 1'b1, 2'd0, ZERO, ONES);
        acc5(1'b1, 1'b1, 3'd0, ZERO, ONES);
        #2;
        rstb = 1'b0;
        rstb5 = 1'b0;
        #1;
        chk("reset_q", q, ZERO);
        chk("reset_init", {260'b0, init_done}, ZERO);
        step();
        step();
        chk("reset_hold_init", {260'b0, init_done}, ZERO);

        // Release; four clear edges, with a write attempt on the second.
        rstb = 1'b1;
        step();
        chk("clear_e1_init", {260'b0, init_done}, ZERO);
        acc(1'b0, 1'b0, 2'd0, BITS'(5), ZERO);
        step();
        chk("clear_e2_init", {260'b0, init_done}, ZERO);
        chk("clear_e2_q", q, ZERO);
        acc(1'b1, 1'b1, 2'd0, ZERO, ONES);
        step();
        chk("clear_e3_init", {260'b0, init_done}, ZERO);
        step();
        chk("clear_e4_init", {260'b0, init_done}, {260'b0, 1'b1});

        for (int i = 0; i < 4; i++) begin
            acc(1'b0, 1'b1, 2'(i), ONES, ZERO);
            step();
            chk($sformatf("cleared_rd_a%0d", i), q, ZERO);
        end

        acc(1'b0, 1'b0, 2'd1, ONES, ZERO);
        step();
`ifndef SRAM_RAND_OUT_EN
        chk("no_write_through", q, ZERO);
`endif
        acc(1'b0, 1'b1, 2'd1, ZERO, ZERO);
        step();
        chk("raw_a1", q, ONES);

        acc(1'b0, 1'b0, 2'd2, ONES, ~LOWER);
        step();
        acc(1'b0, 1'b1, 2'd2, ZERO, ZERO);
        step();
        chk("masked_a2", q, LOWER);

        acc(1'b0, 1'b1, 2'd1, ZERO, ZERO);
        step();
        chk("rd_a1_again", q, ONES);
        for (int i = 0; i < 3; i++) begin
            acc(1'b1, 1'b1, 2'd0, ZERO, ZERO);
            step();
`ifndef SRAM_RAND_OUT_EN
            chk($sformatf("hold_idle%0d", i), q, ONES);
`endif
        end
        acc(1'b0, 1'b0, 2'd3, PAT, ZERO);
        step();
`ifdef SRAM_RAND_OUT_EN
        checks++;
        assert (q !== ONES) else begin
            failures++;
            $error("FAIL rand_out observed=%h expected=not_all_ones", q);
        end
`else
        chk("hold_write", q, ONES);
`endif
        acc(1'b0, 1'b1, 2'd3, ZERO, ZERO);
        step();
        chk("raw_a3", q, PAT);

        acc(1'b0, 1'b0, 2'd3, ~PAT, ~M8);
        step();
        acc(1'b0, 1'b1, 2'd3, ZERO, ZERO);
        step();
        chk("masked_a3", q, PAT ^ M8);

        acc(1'b0, 1'b1, 2'd1, ZERO, ZERO);
        step();
        chk("reread_a1", q, ONES);
        acc(1'b0, 1'b1, 2'd0, ZERO, ZERO);
        step();
        chk("clear_write_ignored_a0", q, ZERO);
        acc(1'b1, 1'b1, 2'd0, ZERO, ONES);

        // Word_Depth=5 instance.
        rstb5 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("d5_clear_e%0d_init", i), {260'b0, init_done5}, {260'b0, (i == 5)});
        end
        acc5(1'b0, 1'b0, 3'd6, ONES, ZERO);
        step();
        acc5(1'b0, 1'b1, 3'd6, ZERO, ZERO);
        step();
        for (int i = 0; i < 5; i++) begin
            acc5(1'b0, 1'b1, 3'(i), ZERO, ZERO);
            step();
            chk($sformatf("d5_oob_untouched_a%0d", i), q5, ZERO);
        end
        acc5(1'b0, 1'b0, 3'd4, ONES, ZERO);
        step();
        acc5(1'b0, 1'b1, 3'd4, ZERO, ZERO);
        step();
        chk("d5_rd_a4", q5, ONES);

        acc5(1'b0, 1'b0, 3'd0, ONES, ZERO);
        step();
        acc5(1'b0, 1'b0, 3'd1, ONES, ZERO);
        step();
        #3;
        rstb5 = 1'b0;
        #1;
        chk("d5_async_q", q5, ZERO);
        chk("d5_async_init", {260'b0, init_done5}, ZERO);
        step();
        rstb5 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("d5_reclear_e%0d_init", i), {260'b0, init_done5}, {260'b0, (i == 5)});
        end
        acc5(1'b0, 1'b1, 3'd4, ZERO, ZERO);
        step();
        chk("d5_lost_a4", q5, ZERO);
        acc5(1'b0, 1'b1, 3'd1, ZERO, ZERO);
        step();
        chk("d5_lost_a1", q5, ZERO);
        acc5(1'b1, 1'b1, 3'd0, ZERO, ONES);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
